// File: rtl/load_store_unit.sv
// load_store_unit: MIPS memory stage, sub-word load/store onto a word-only RAM port
module load_store_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        uns_i,
    input  logic [7:0]  addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        done_o,
    output logic        err_o,
    output logic        busy_o,
    output logic [7:0]  ram_address_o,
    output logic [31:0] ram_data_in_o,
    input  logic [31:0] ram_data_out_i,
    output logic        ram_write_o,
    output logic        ram_cs_o
);
    typedef enum logic [2:0] {IDLE, LD, RMW_RD, WR, FIN} state_t;

    state_t      state_q, state_d;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [7:0]  addr_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;
    logic [31:0] merge_q;
    logic        bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_v;
    logic [31:0] merge_v;

    assign bad = (size_i == 2'b10) || (size_i == 2'b01 && addr_i[0]) || (size_i == 2'b11 && addr_i[1:0] != 2'b00);

    // Next-state decode; errors skip RAM entirely and go straight to FIN
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_i) state_d = bad ? FIN : !we_i ? LD : size_i == 2'b11 ? WR : RMW_RD;
            LD:      state_d = FIN;
            RMW_RD:  state_d = WR;
            WR:      state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Lane extraction for loads and lane replacement for read-modify-write stores
    always_comb begin
        byte_v  = ram_data_out_i[{addr_q[1:0], 3'b000} +: 8];
        half_v  = addr_q[1] ? ram_data_out_i[31:16] : ram_data_out_i[15:0];
        load_v  = size_q == 2'b11 ? ram_data_out_i :
                  size_q == 2'b01 ? {{16{~uns_q & half_v[15]}}, half_v} :
                                    {{24{~uns_q & byte_v[7]}}, byte_v};
        merge_v = ram_data_out_i;
        if (size_q == 2'b01)
            merge_v[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merge_v[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    // State, request capture, load result and merge register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 8'h00;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            merge_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req_i) begin
                size_q  <= size_i;
                uns_q   <= uns_i;
                addr_q  <= addr_i;
                wdata_q <= wdata_i;
                err_q   <= bad;
            end
            if (state_q == LD) rdata_q <= load_v;
            if (state_q == RMW_RD) merge_q <= merge_v;
        end
    end

    assign rdata_o       = rdata_q;
    assign done_o        = state_q == FIN;
    assign err_o         = state_q == FIN && err_q;
    assign busy_o        = state_q != IDLE;
    assign ram_address_o = {addr_q[7:2], 2'b00};
    assign ram_cs_o      = !rst_i && (state_q == LD || state_q == RMW_RD);
    assign ram_write_o   = !rst_i && state_q == WR;
    assign ram_data_in_o = ram_write_o ? (size_q == 2'b11 ? wdata_q : merge_q) : 32'h0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a behavioural word RAM
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [7:0]  addr = 8'h00;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        done, err, busy;
    logic [7:0]  ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write, ram_cs;
    logic [31:0] mem [0:63];

    int n_vec = 0;
    int n_bad = 0;
    int cs_cnt = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int both_cnt = 0;
    logic [7:0]  last_waddr = 8'h00;
    logic [31:0] last_wdata = 32'h0;
    int lat;
    logic e;

    load_store_unit dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size), .uns_i(uns),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .done_o(done), .err_o(err),
        .busy_o(busy), .ram_address_o(ram_address), .ram_data_in_o(ram_data_in),
        .ram_data_out_i(mem[ram_address[7:2]]), .ram_write_o(ram_write), .ram_cs_o(ram_cs)
    );

    always #5 clk = ~clk;

    // RAM write port
    always @(posedge clk) if (ram_write) mem[ram_address[7:2]] <= ram_data_in;

    // Bus activity monitor
    always @(negedge clk) begin
        if (ram_cs) cs_cnt++;
        if (done) done_cnt++;
        if (ram_cs && ram_write) both_cnt++;
        if (ram_write) begin
            wr_cnt++;
            last_waddr = ram_address;
            last_wdata = ram_data_in;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run(input logic w, input logic [1:0] s, input logic u, input logic [7:0] a,
                       input logic [31:0] d, output int l, output logic er);
        @(negedge clk);
        cs_cnt = 0; wr_cnt = 0; done_cnt = 0; both_cnt = 0;
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1 req = 1'b0;
        l = 0;
        er = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (done) begin
                l = i;
                er = err;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4]  = 32'h11223344;
        mem[9]  = 32'h5555AAAA;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1 check("reset_outputs", {24'h0, done, err, busy, ram_cs, ram_write}, 32'h0);
        check("reset_rdata", rdata, 32'h0);

        // reset during WR of sw 0x10
        @(negedge clk);
        cs_cnt = 0; wr_cnt = 0; done_cnt = 0;
        req = 1'b1; we = 1'b1; size = 2'b11; addr = 8'h10; wdata = 32'hAABBCCDD;
        @(posedge clk);
        #1 req = 1'b0;
        rst = 1'b1;
        #1 check("rst_wr_forced_low", {31'h0, ram_write}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("rst_abort_outputs", {24'h0, done, err, busy, ram_cs, ram_write}, 32'h0);
        check("rst_abort_addr", {24'h0, ram_address}, 32'h0);
        check("rst_abort_din", ram_data_in, 32'h0);
        repeat (3) @(negedge clk);
        check("rst_no_write", wr_cnt, 0);
        check("rst_no_done", done_cnt, 0);
        run(1'b0, 2'b11, 1'b0, 8'h10, 32'h0, lat, e);
        check("rst_lw_prior", rdata, 32'h11223344);

        // word store / load
        run(1'b1, 2'b11, 1'b0, 8'h20, 32'h12345678, lat, e);
        check("sw_lat", lat, 2);
        check("sw_writes", wr_cnt, 1);
        run(1'b0, 2'b11, 1'b0, 8'h20, 32'h0, lat, e);
        check("lw_data", rdata, 32'h12345678);
        check("lw_lat", lat, 2);
        check("lw_err", {31'h0, e}, 32'h0);

        // byte store via read-modify-write
        run(1'b1, 2'b00, 1'b0, 8'h22, 32'hFFFFFFAB, lat, e);
        check("sb_lat", lat, 3);
        check("sb_writes", wr_cnt, 1);
        check("sb_waddr", {24'h0, last_waddr}, 32'h20);
        check("sb_wdata", last_wdata, 32'h12AB5678);
        check("sb_mem", mem[8], 32'h12AB5678);
        run(1'b0, 2'b00, 1'b0, 8'h22, 32'h0, lat, e);
        check("lb", rdata, 32'hFFFFFFAB);
        run(1'b0, 2'b00, 1'b1, 8'h22, 32'h0, lat, e);
        check("lbu", rdata, 32'h000000AB);

        // halfword store / loads
        run(1'b1, 2'b01, 1'b0, 8'h26, 32'h00008001, lat, e);
        check("sh_lat", lat, 3);
        run(1'b0, 2'b01, 1'b0, 8'h26, 32'h0, lat, e);
        check("lh", rdata, 32'hFFFF8001);
        run(1'b0, 2'b01, 1'b1, 8'h26, 32'h0, lat, e);
        check("lhu", rdata, 32'h00008001);
        run(1'b0, 2'b11, 1'b0, 8'h24, 32'h0, lat, e);
        check("lw_after_sh", rdata, 32'h8001AAAA);

        // error cases: {we, size, addr}
        run(1'b0, 2'b11, 1'b0, 8'h21, 32'h0, lat, e);
        check("lw_mis_err", {31'h0, e}, 32'h1);
        check("lw_mis_lat", lat, 1);
        check("lw_mis_bus", cs_cnt + wr_cnt, 0);
        check("lw_mis_rdata", rdata, 32'h8001AAAA);
        run(1'b1, 2'b01, 1'b0, 8'h23, 32'h0000BEEF, lat, e);
        check("sh_mis_err", {31'h0, e}, 32'h1);
        check("sh_mis_lat", lat, 1);
        check("sh_mis_bus", cs_cnt + wr_cnt, 0);
        check("sh_mis_mem", mem[8], 32'h12AB5678);
        run(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lat, e);
        check("size10_err", {31'h0, e}, 32'h1);
        check("size10_lat", lat, 1);
        check("size10_bus", cs_cnt + wr_cnt, 0);
        check("size10_rdata", rdata, 32'h8001AAAA);

        // req held high through busy period
        @(negedge clk);
        cs_cnt = 0; wr_cnt = 0; done_cnt = 0;
        req = 1'b1; we = 1'b0; size = 2'b11; uns = 1'b0; addr = 8'h20;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) break;
        end
        req = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_done_cnt", done_cnt, 1);
        check("stall_cs_cnt", cs_cnt, 1);
        check("stall_rdata", rdata, 32'h12AB5678);

        // top word boundary
        run(1'b1, 2'b11, 1'b0, 8'd252, 32'hDEADBEEF, lat, e);
        check("top_waddr", {24'h0, last_waddr}, 32'hFC);
        run(1'b0, 2'b00, 1'b0, 8'd255, 32'h0, lat, e);
        check("lb_255", rdata, 32'hFFFFFFDE);
        check("never_cs_and_write", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
